// File: rtl/bf16_pkg.sv
// Shared BFloat16 types, constants and operand classification helpers.
package bf16_pkg;

    localparam int unsigned E    = 8;
    localparam int unsigned M    = 7;
    localparam int unsigned BIAS = 127;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
    } bf16_t;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam logic [6:0] QNAN_MAN = 7'h7F;
    localparam bf16_t      ZERO     = '0;

    function automatic logic is_nan(input bf16_t x);
        return (x.e == EXP_MAX) && (x.m != '0);
    endfunction

    function automatic logic is_inf(input bf16_t x);
        return (x.e == EXP_MAX) && (x.m == '0);
    endfunction

    // Exponent zero is zero; denormal mantissas are ignored.
    function automatic logic is_zero(input bf16_t x);
        return x.e == '0;
    endfunction

endpackage

// File: rtl/bf16_lzc.sv
// Leading-zero counter used to renormalize after effective subtraction.
module bf16_lzc #(
    parameter int unsigned W  = 11,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  in,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (in[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bf16_adder.sv
// BFloat16 adder: RNE rounding, denormal flush-to-zero, canonical NaN, one-cycle registered result.
module bf16_adder #(
    parameter int unsigned E = 8,
    parameter int unsigned M = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sa_i,
    input  logic [E-1:0] ea_i,
    input  logic [M-1:0] ma_i,
    input  logic         sb_i,
    input  logic [E-1:0] eb_i,
    input  logic [M-1:0] mb_i,
    output logic         s_o,
    output logic [E-1:0] e_o,
    output logic [M-1:0] m_o
);
    import bf16_pkg::*;

    bf16_t a, b, big, sml, res_d, res_q;
    logic        a_is_big, eff_sub, round_up;
    logic [7:0]  ediff;
    logic [17:0] sml_sh;
    logic [10:0] big_x, sml_x, diff, norm;
    logic [11:0] sum;
    logic [3:0]  lz;
    logic [8:0]  rnd;
    logic signed [9:0] exp_n, exp_r;

    assign a = {sa_i, ea_i, ma_i};
    assign b = {sb_i, eb_i, mb_i};

    assign a_is_big = {ea_i, ma_i} >= {eb_i, mb_i};
    assign big      = a_is_big ? a : b;
    assign sml      = a_is_big ? b : a;
    assign eff_sub  = sa_i ^ sb_i;
    assign ediff    = big.e - sml.e;

    // Extended field is {significand, guard, round, sticky}.
    assign big_x  = {1'b1, big.m, 3'b000};
    assign sml_sh = {1'b1, sml.m, 10'b0} >> ediff;
    assign sml_x  = (ediff >= 8'd10) ? 11'd1 : {sml_sh[17:8], |sml_sh[7:0]};
    assign sum    = {1'b0, big_x} + {1'b0, sml_x};
    assign diff   = big_x - sml_x;

    bf16_lzc #(
        .W  (11),
        .CW (4)
    ) u_lzc (
        .in  (diff),
        .cnt (lz)
    );

    always_comb begin
        norm  = '0;
        exp_n = $signed({2'b00, big.e});
        if (!eff_sub) begin
            if (sum[11]) begin
                norm  = {sum[11:2], |sum[1:0]};
                exp_n = $signed({2'b00, big.e}) + 10'sd1;
            end else begin
                norm = sum[10:0];
            end
        end else begin
            norm  = diff << lz;
            exp_n = $signed({2'b00, big.e}) - $signed({6'b0, lz});
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[10:3]} + {8'b0, round_up};
        exp_r    = rnd[8] ? exp_n + 10'sd1 : exp_n;
    end

    always_comb begin
        res_d = ZERO;
        if (is_nan(a)) begin
            res_d = {sa_i, EXP_MAX, QNAN_MAN};
        end else if (is_nan(b)) begin
            res_d = {sb_i, EXP_MAX, QNAN_MAN};
        end else if (is_inf(a) && is_inf(b)) begin
            res_d = eff_sub ? {1'b0, EXP_MAX, QNAN_MAN} : {sa_i, EXP_MAX, 7'h00};
        end else if (is_inf(a)) begin
            res_d = a;
        end else if (is_inf(b)) begin
            res_d = b;
        end else if (is_zero(a) && is_zero(b)) begin
            res_d = {sa_i & sb_i, 8'h00, 7'h00};
        end else if (is_zero(a)) begin
            res_d = b;
        end else if (is_zero(b)) begin
            res_d = a;
        end else if (eff_sub && diff == '0) begin
            res_d = ZERO;
        end else if (exp_r >= 10'sd255) begin
            res_d = {big.s, EXP_MAX, 7'h00};
        end else if (exp_r <= 10'sd0) begin
            res_d = {big.s, 8'h00, 7'h00};
        end else begin
            res_d = {big.s, exp_r[7:0], rnd[8] ? rnd[7:1] : rnd[6:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q <= ZERO;
        end else begin
            res_q <= res_d;
        end
    end

    assign s_o = res_q.s;
    assign e_o = res_q.e;
    assign m_o = res_q.m;

endmodule

// File: tb/tb_bf16_adder.sv
// Directed bench for bf16_adder; expected results queue at drive time and retire one cycle later.
module tb_bf16_adder;
    import bf16_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sa, sb, s_out;
    logic [7:0] ea, eb, e_out;
    logic [6:0] ma, mb, m_out;

    int vectors = 0;
    int miscompares = 0;
    bf16_t exp_q[$];
    string tag_q[$];

    bf16_adder #(
        .E (8),
        .M (7)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sa_i  (sa),
        .ea_i  (ea),
        .ma_i  (ma),
        .sb_i  (sb),
        .eb_i  (eb),
        .mb_i  (mb),
        .s_o   (s_out),
        .e_o   (e_out),
        .m_o   (m_out)
    );

    always #5 clk = ~clk;

    task automatic check();
        bf16_t want, got;
        string tag;
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got  = {s_out, e_out, m_out};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Drive one operation, queue its expectation, sample just after the capturing edge.
    task automatic apply(input bf16_t a, input bf16_t b, input bf16_t want, input string tag);
        {sa, ea, ma} = a;
        {sb, eb, mb} = b;
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        bf16_t na, rb;
        rst = 1'b1;
        {sa, ea, ma} = '0;
        {sb, eb, mb} = '0;
        apply({1'b0, 8'h7F, 7'h00}, {1'b0, 8'h7F, 7'h00}, {1'b0, 8'h00, 7'h00}, "reset_state");
        rst = 1'b0;

        apply({1'b0, 8'h00, 7'h00}, {1'b0, 8'h00, 7'h00}, {1'b0, 8'h00, 7'h00}, "pz_pz");
        apply({1'b0, 8'h00, 7'h00}, {1'b1, 8'h00, 7'h00}, {1'b0, 8'h00, 7'h00}, "pz_nz");
        apply({1'b1, 8'h00, 7'h00}, {1'b1, 8'h00, 7'h00}, {1'b1, 8'h00, 7'h00}, "nz_nz");
        apply({1'b0, 8'h00, 7'h00}, {1'b0, 8'h7F, 7'h00}, {1'b0, 8'h7F, 7'h00}, "pz_one");
        apply({1'b1, 8'h00, 7'h00}, {1'b0, 8'h7F, 7'h00}, {1'b0, 8'h7F, 7'h00}, "nz_one");
        apply({1'b1, 8'h00, 7'h00}, {1'b1, 8'h7F, 7'h00}, {1'b1, 8'h7F, 7'h00}, "nz_negone");
        apply({1'b0, 8'h00, 7'h00}, {1'b1, 8'h7F, 7'h00}, {1'b1, 8'h7F, 7'h00}, "pz_negone");
        apply({1'b0, 8'h00, 7'h55}, {1'b0, 8'h80, 7'h10}, {1'b0, 8'h80, 7'h10}, "denorm_flush");

        for (int i = 0; i < 100; i++) begin
            na = {1'($urandom), 8'hFF, 7'($urandom_range(1, 127))};
            rb = bf16_t'($urandom);
            apply(na, rb, {na.s, 8'hFF, 7'h7F}, "nan_a");
        end
        apply({1'b0, 8'h7F, 7'h00}, {1'b1, 8'hFF, 7'h01}, {1'b1, 8'hFF, 7'h7F}, "nan_b");

        apply({1'b0, 8'h7F, 7'h00}, {1'b0, 8'h7F, 7'h00}, {1'b0, 8'h80, 7'h00}, "one_plus_one");
        apply({1'b0, 8'h7F, 7'h00}, {1'b1, 8'h7F, 7'h00}, {1'b0, 8'h00, 7'h00}, "cancel");
        apply({1'b0, 8'h7F, 7'h00}, {1'b0, 8'h7E, 7'h00}, {1'b0, 8'h7F, 7'h40}, "one_plus_half");
        apply({1'b0, 8'h7F, 7'h00}, {1'b1, 8'h7E, 7'h40}, {1'b0, 8'h7D, 7'h00}, "one_minus_3q");
        // 1.9921875 + 2^-8 is an exact half-ulp tie on an odd mantissa: rounds up and carries.
        apply({1'b0, 8'h7F, 7'h7F}, {1'b0, 8'h77, 7'h00}, {1'b0, 8'h80, 7'h00}, "tie_up_carry");
        apply({1'b0, 8'h7F, 7'h7F}, {1'b0, 8'h76, 7'h00}, {1'b0, 8'h7F, 7'h7F}, "quarter_ulp");
        apply({1'b0, 8'h7F, 7'h00}, {1'b0, 8'h77, 7'h00}, {1'b0, 8'h7F, 7'h00}, "tie_even_down");
        apply({1'b0, 8'h7F, 7'h00}, {1'b1, 8'h60, 7'h00}, {1'b0, 8'h7F, 7'h00}, "tiny_sub");

        apply({1'b0, 8'hFF, 7'h00}, {1'b1, 8'hFF, 7'h00}, {1'b0, 8'hFF, 7'h7F}, "inf_minus_inf");
        apply({1'b1, 8'hFF, 7'h00}, {1'b1, 8'hFF, 7'h00}, {1'b1, 8'hFF, 7'h00}, "ninf_ninf");
        apply({1'b0, 8'hFF, 7'h00}, {1'b0, 8'h81, 7'h20}, {1'b0, 8'hFF, 7'h00}, "inf_plus_5");
        apply({1'b0, 8'h7F, 7'h00}, {1'b1, 8'hFF, 7'h00}, {1'b1, 8'hFF, 7'h00}, "one_plus_ninf");
        apply({1'b0, 8'hFE, 7'h7F}, {1'b0, 8'hFE, 7'h7F}, {1'b0, 8'hFF, 7'h00}, "overflow");
        apply({1'b0, 8'hFE, 7'h7F}, {1'b0, 8'hF6, 7'h00}, {1'b0, 8'hFF, 7'h00}, "round_overflow");
        apply({1'b1, 8'h01, 7'h40}, {1'b0, 8'h01, 7'h00}, {1'b1, 8'h00, 7'h00}, "underflow");

        rst = 1'b1;
        apply({1'b0, 8'h80, 7'h00}, {1'b0, 8'h80, 7'h00}, {1'b0, 8'h00, 7'h00}, "mid_reset");
        rst = 1'b0;
        apply({1'b0, 8'h80, 7'h00}, {1'b0, 8'h80, 7'h00}, {1'b0, 8'h81, 7'h00}, "after_reset");
        apply({1'b0, 8'h80, 7'h00}, {1'b0, 8'h80, 7'h00}, {1'b0, 8'h81, 7'h00}, "hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
